// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader for the CPU instruction memory.
// Frame: SYNC_BYTE, word count N, 2N payload bytes (hi, lo), XOR checksum.
// The CPU is held in reset until a frame with a matching checksum has been
// written completely. Every output is driven straight from a register.
module imem_loader #(
  parameter int          ADDR_W    = 8,
  parameter int          DATA_W    = 16,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  // The word counter and the latched count must hold both any 8-bit count
  // byte and the memory depth itself, so that an over-long frame is caught.
  localparam int CNT_W = (ADDR_W >= 8) ? (ADDR_W + 1) : 9;
  localparam logic [CNT_W-1:0] DEPTH = {{(CNT_W-1){1'b0}}, 1'b1} << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_WR    = 3'd4,
    S_CHK   = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  // Running frame checksum: XOR of every payload byte.
  function automatic logic [7:0] f_csum_next(input logic [7:0] csum,
                                             input logic [7:0] data_byte);
    f_csum_next = csum ^ data_byte;
  endfunction

  state_t              r_state;
  logic                r_in_ready;
  logic                r_imem_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_cpu_reset;
  logic                r_done;
  logic                r_error;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    r_n;
  logic [7:0]          r_csum;

  logic                w_accept;
  logic                w_is_sync;
  logic [CNT_W-1:0]    w_n_ext;
  logic [CNT_W-1:0]    w_cnt_next;
  logic [ADDR_W-1:0]   w_addr_next;

  assign w_accept    = in_valid & r_in_ready;
  assign w_is_sync   = (in_data == SYNC_BYTE);
  assign w_n_ext     = {{(CNT_W-8){1'b0}}, in_data};
  assign w_cnt_next  = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  assign w_addr_next = r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};

  assign in_ready   = r_in_ready;
  assign imem_we    = r_imem_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign cpu_reset  = r_cpu_reset;
  assign done       = r_done;
  assign error      = r_error;

  // Frame parser, instmem write sequencing and CPU reset release.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_imem_we   <= 1'b0;
      r_addr      <= {ADDR_W{1'b0}};
      r_wdata     <= {DATA_W{1'b0}};
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_cnt       <= {CNT_W{1'b0}};
      r_n         <= {CNT_W{1'b0}};
      r_csum      <= 8'h00;
    end else begin
      case (r_state)
        // Waiting for a frame; DONE and ERR behave identically here except
        // that they keep reporting the outcome of the previous frame.
        S_IDLE, S_DONE, S_ERR: begin
          if (w_accept && w_is_sync) begin
            r_csum      <= 8'h00;
            r_addr      <= {ADDR_W{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_state     <= S_COUNT;
          end
        end

        S_COUNT: begin
          if (w_accept) begin
            r_n <= w_n_ext;
            if (w_n_ext > DEPTH) begin
              r_error <= 1'b1;
              r_state <= S_ERR;
            end else if (w_n_ext == {CNT_W{1'b0}}) begin
              r_state <= S_CHK;
            end else begin
              r_state <= S_HI;
            end
          end
        end

        S_HI: begin
          if (w_accept) begin
            r_wdata[DATA_W-1:DATA_W-8] <= in_data;
            r_csum  <= f_csum_next(r_csum, in_data);
            r_state <= S_LO;
          end
        end

        // The low byte completes a word: strobe the write for one cycle and
        // stall the stream so the address can advance before the next word.
        S_LO: begin
          if (w_accept) begin
            r_wdata[7:0] <= in_data;
            r_csum     <= f_csum_next(r_csum, in_data);
            r_imem_we  <= 1'b1;
            r_in_ready <= 1'b0;
            r_state    <= S_WR;
          end
        end

        S_WR: begin
          r_imem_we  <= 1'b0;
          r_in_ready <= 1'b1;
          r_addr     <= w_addr_next;
          r_cnt      <= w_cnt_next;
          if (w_cnt_next == r_n) begin
            r_state <= S_CHK;
          end else begin
            r_state <= S_HI;
          end
        end

        // Release the CPU on the same edge the good checksum is taken.
        S_CHK: begin
          if (w_accept) begin
            if (in_data == r_csum) begin
              r_done      <= 1'b1;
              r_cpu_reset <= 1'b0;
              r_state     <= S_DONE;
            end else begin
              r_error <= 1'b1;
              r_state <= S_ERR;
            end
          end
        end

        default: begin
          r_imem_we  <= 1'b0;
          r_in_ready <= 1'b1;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. Expected instmem writes are queued
// by each test as it drives a frame and are compared by a monitor when the
// DUT strobes imem_we.
module tb_imem_loader;

  logic        CLK;
  logic        RESET;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;

  int checks   = 0;
  int failures = 0;
  int acc_cnt  = 0;
  int stall_cnt = 0;

  logic [23:0] exp_q[$];   // {addr[7:0], data[15:0]}

  imem_loader #(.ADDR_W(8), .DATA_W(16), .SYNC_BYTE(8'hA5)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Monitor: samples mid-cycle, before the next rising edge.
  always @(negedge CLK) begin
    #2;
    if (in_valid && in_ready) acc_cnt++;
    if (in_valid && !in_ready) stall_cnt++;
    if (imem_we) begin
      logic [23:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%h data=%h", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          failures++;
          $display("FAIL write got addr=%h data=%h expected addr=%h data=%h",
                   imem_addr, imem_wdata, e[23:16], e[15:0]);
        end
      end
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL ready_in_wr got=%b expected=0", in_ready);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    if (guard >= 20) begin
      checks++;
      failures++;
      $display("FAIL send_timeout byte=%h in_ready=%b expected=1", b, in_ready);
    end
    @(negedge CLK);
  endtask

  task automatic send_seq(input logic [7:0] seq[$]);
    foreach (seq[i]) send_byte(seq[i]);
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic drain(input string name);
    repeat (3) @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s missing_writes got=%0d expected=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_status(input string name, input logic exp_done,
                              input logic exp_err, input logic exp_cpu);
    checks++;
    if ({done, error, cpu_reset} !== {exp_done, exp_err, exp_cpu}) begin
      failures++;
      $display("FAIL %s done/error/cpu_reset got=%b%b%b expected=%b%b%b",
               name, done, error, cpu_reset, exp_done, exp_err, exp_cpu);
    end
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if ({in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error} !==
        {1'b1, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL %s rdy=%b we=%b addr=%h wdata=%h cpu=%b done=%b err=%b expected 1 0 00 0000 1 0 0",
               name, in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (2) @(negedge CLK);
    check_reset_vals("reset_values");
    RESET = 1'b0;
    @(negedge CLK);
    check_reset_vals("after_reset_release");
  endtask

  task automatic test_load();
    exp_q.push_back({8'h00, 16'h98C1});
    exp_q.push_back({8'h01, 16'h9906});
    send_seq('{8'hA5, 8'h02, 8'h98, 8'hC1, 8'h99, 8'h06});
    check_status("load_before_csum", 1'b0, 1'b0, 1'b1);
    send_byte(8'hC6);
    in_valid = 1'b0;
    check_status("load_done_edge", 1'b1, 1'b0, 1'b0);
    drain("load");
  endtask

  task automatic test_bad_csum();
    exp_q.push_back({8'h00, 16'h98C1});
    exp_q.push_back({8'h01, 16'h9906});
    send_seq('{8'hA5});
    check_status("restart_sync", 1'b0, 1'b0, 1'b1);
    send_seq('{8'h02, 8'h98, 8'hC1, 8'h99, 8'h06, 8'hC7});
    check_status("bad_csum", 1'b0, 1'b1, 1'b1);
    drain("bad_csum");
  endtask

  task automatic test_back_to_back();
    acc_cnt = 0;
    stall_cnt = 0;
    exp_q.push_back({8'h00, 16'h1122});
    exp_q.push_back({8'h01, 16'h3344});
    send_seq('{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44});
    drain("back_to_back");
    checks++;
    if (acc_cnt != 7) begin
      failures++;
      $display("FAIL bp_accepted got=%0d expected=7", acc_cnt);
    end
    checks++;
    if (stall_cnt != 2) begin
      failures++;
      $display("FAIL bp_stall_cycles got=%0d expected=2", stall_cnt);
    end
    check_status("bp_done", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_garbage();
    send_seq('{8'hA5, 8'h00, 8'h05});   // leave the loader in ERR first
    check_status("garbage_pre_err", 1'b0, 1'b1, 1'b1);
    exp_q.push_back({8'h00, 16'h2021});
    send_seq('{8'h00, 8'hFF, 8'h12});
    check_status("garbage_discarded", 1'b0, 1'b1, 1'b1);
    send_seq('{8'hA5, 8'h01, 8'h20, 8'h21, 8'h01});
    check_status("garbage_done", 1'b1, 1'b0, 1'b0);
    drain("garbage");
  endtask

  task automatic test_empty();
    send_seq('{8'hA5, 8'h00, 8'h00});
    check_status("empty_ok", 1'b1, 1'b0, 1'b0);
    send_seq('{8'hA5, 8'h00, 8'h01});
    check_status("empty_bad", 1'b0, 1'b1, 1'b1);
    drain("empty");
  endtask

  task automatic test_reset_mid();
    send_seq('{8'hA5, 8'h02, 8'h98});
    RESET = 1'b1;
    #1;
    check_reset_vals("mid_reset_async");
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check_reset_vals("mid_reset_after");
    drain("mid_reset_nowrite");
    exp_q.push_back({8'h00, 16'h1234});
    send_seq('{8'hA5, 8'h01, 8'h12, 8'h34});
    check_status("mid_reload_pending", 1'b0, 1'b0, 1'b1);
    send_seq('{8'h26});
    check_status("mid_reload_done", 1'b1, 1'b0, 1'b0);
    drain("mid_reload");
  endtask

  initial begin
    RESET = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    @(negedge CLK);
    test_reset();
    test_load();
    test_bad_csum();
    test_back_to_back();
    test_garbage();
    test_empty();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
